// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared defaults and types for the register file with busy scoreboard.
// Contents:
//   DEFAULT_XLEN / DEFAULT_DEPTH / DEFAULT_NUM_RD : default parameter values
//   DEFAULT_AW                                    : address width for DEFAULT_DEPTH
//   reg_addr_t / reg_data_t                       : address and data types at default sizes
//   ZERO_REG                                      : architectural zero register address
package regfile_pkg;

    localparam int DEFAULT_XLEN   = 32;
    localparam int DEFAULT_DEPTH  = 32;
    localparam int DEFAULT_NUM_RD = 2;
    localparam int DEFAULT_AW     = $clog2(DEFAULT_DEPTH);

    typedef logic [DEFAULT_AW-1:0]   reg_addr_t;
    typedef logic [DEFAULT_XLEN-1:0] reg_data_t;

    localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Per-register busy bits: set when decode reserves a destination, cleared when
// writeback writes that register.
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset (clears all busy bits)
//   write_en, write_add  : writeback strobe and destination (clears busy)
//   issue_valid          : decode requests a reservation of issue_add
//   issue_add            : destination to reserve
//   issue_ready          : reservation can be accepted this cycle (combinational)
//   busy_vec             : bit r set while register r has a pending write
//
// Issue handshake: a reservation completes on a posedge where issue_valid and
// issue_ready are both 1. issue_ready never depends on issue_valid. While
// issue_valid=1 and issue_ready=0 the requester holds issue_add stable.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             write_en,
    input  logic [AW-1:0]    write_add,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_add,
    output logic             issue_ready,
    output logic [DEPTH-1:0] busy_vec
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             issue_fire;

    // A writeback landing on the requested register this cycle frees it, so
    // the new reservation may be accepted in the same cycle.
    always_comb begin
        issue_ready = rst_n & ((issue_add == ZERO_ADDR) |
                               ~busy_q[issue_add] |
                               (write_en & (write_add == issue_add)));
        issue_fire  = issue_valid & issue_ready;
    end

    // Clear first, then set: when both hit the same register the new
    // producer keeps ownership.
    always_comb begin
        busy_d = busy_q;
        if (write_en && (write_add != ZERO_ADDR)) begin
            busy_d[write_add] = 1'b0;
        end
        if (issue_fire && (issue_add != ZERO_ADDR)) begin
            busy_d[issue_add] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb
// Register file with NUM_RD asynchronous read ports, one synchronous write
// port, a hard-wired zero register and a busy scoreboard for hazard stalls.
// Optional build macro: REGFILE_BYPASS_EN enables write-through forwarding of
// the writeback data onto read ports addressing the register being written.
// Ports:
//   clk, rst_n                        : clock, synchronous active-low reset
//   write_en, WriteAdd, Reg_WriteData : writeback write port
//   ReadAdd  [NUM_RD*AW]              : packed read addresses, port i = [i*AW +: AW]
//   Data     [NUM_RD*XLEN]            : packed read data, port i = [i*XLEN +: XLEN]
//   rd_busy  [NUM_RD]                 : read port i addresses a register with a pending write
//   issue_valid, IssueAdd, issue_ready: destination reservation handshake
//   busy_vec [DEPTH]                  : scoreboard state
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN   = DEFAULT_XLEN,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int NUM_RD = DEFAULT_NUM_RD,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   write_en,
    input  logic [AW-1:0]          WriteAdd,
    input  logic [XLEN-1:0]        Reg_WriteData,
    input  logic [NUM_RD*AW-1:0]   ReadAdd,
    output logic [NUM_RD*XLEN-1:0] Data,
    output logic [NUM_RD-1:0]      rd_busy,
    input  logic                   issue_valid,
    input  logic [AW-1:0]          IssueAdd,
    output logic                   issue_ready,
    output logic [DEPTH-1:0]       busy_vec
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [XLEN-1:0] mem_d [DEPTH];
    logic            wr_hit;

    assign wr_hit = write_en & (WriteAdd != ZERO_ADDR);

    always_comb begin
        mem_d = mem_q;
        if (wr_hit) begin
            mem_d[WriteAdd] = Reg_WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    regfile_scoreboard #(
        .DEPTH (DEPTH)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .write_en    (write_en),
        .write_add   (WriteAdd),
        .issue_valid (issue_valid),
        .issue_add   (IssueAdd),
        .issue_ready (issue_ready),
        .busy_vec    (busy_vec)
    );

    // Register 0 reads as zero and is never busy regardless of storage.
    always_comb begin
        Data    = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (ReadAdd[i*AW +: AW] != ZERO_ADDR) begin
                Data[i*XLEN +: XLEN] = mem_q[ReadAdd[i*AW +: AW]];
                rd_busy[i]           = busy_vec[ReadAdd[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                // Forwarding is suppressed in reset, where the write is ignored.
                if (rst_n && wr_hit && (WriteAdd == ReadAdd[i*AW +: AW])) begin
                    Data[i*XLEN +: XLEN] = Reg_WriteData;
                    rd_busy[i]           = 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  localparam int XLEN   = 32;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 2;
  localparam int AW     = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic                   rst_n = 1'b0;
  logic                   write_en = 1'b0;
  logic [AW-1:0]          WriteAdd = '0;
  logic [XLEN-1:0]        Reg_WriteData = '0;
  logic [NUM_RD*AW-1:0]   ReadAdd = '0;
  logic [NUM_RD*XLEN-1:0] Data;
  logic [NUM_RD-1:0]      rd_busy;
  logic                   issue_valid = 1'b0;
  logic [AW-1:0]          IssueAdd = '0;
  logic                   issue_ready;
  logic [DEPTH-1:0]       busy_vec;

  regfile_sb #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .write_en      (write_en),
    .WriteAdd      (WriteAdd),
    .Reg_WriteData (Reg_WriteData),
    .ReadAdd       (ReadAdd),
    .Data          (Data),
    .rd_busy       (rd_busy),
    .issue_valid   (issue_valid),
    .IssueAdd      (IssueAdd),
    .issue_ready   (issue_ready),
    .busy_vec      (busy_vec)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks = 0;
  int failures = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Literal expectations queued by the directed sequence, popped against port 0.
  task automatic pin_data0(input string name);
    logic [XLEN-1:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_queue_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check(name, {32'd0, Data[31:0]}, {32'd0, e});
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [XLEN-1:0] m_reg [DEPTH];
  bit              m_busy [DEPTH];
  bit              model_valid = 0;
  bit              stall_hold = 0;

  // Inputs change 1 time unit after posedge; negedge sees them settled and
  // the model is advanced to what the coming posedge must produce.
  always @(negedge clk) begin
    logic [AW-1:0]    a;
    logic [XLEN-1:0]  exp_d;
    logic             exp_b;
    logic             exp_ready;
    logic [DEPTH-1:0] exp_vec;
    exp_ready = rst_n && (IssueAdd == 0 || !m_busy[IssueAdd] ||
                          (write_en && WriteAdd == IssueAdd));
    if (model_valid) begin
      for (int i = 0; i < NUM_RD; i++) begin
        a = ReadAdd[i*AW +: AW];
        exp_d = (a == 0) ? '0 : m_reg[a];
        exp_b = (a != 0) && m_busy[a];
`ifdef REGFILE_BYPASS_EN
        if (rst_n && write_en && WriteAdd == a && a != 0) begin
          exp_d = Reg_WriteData;
          exp_b = 1'b0;
        end
`endif
        check($sformatf("data%0d", i), {32'd0, Data[i*XLEN +: XLEN]}, {32'd0, exp_d});
        check($sformatf("rd_busy%0d", i), {63'd0, rd_busy[i]}, {63'd0, exp_b});
      end
      check("issue_ready", {63'd0, issue_ready}, {63'd0, exp_ready});
      for (int r = 0; r < DEPTH; r++) exp_vec[r] = m_busy[r];
      check("busy_vec", {32'd0, busy_vec}, {32'd0, exp_vec});
    end
    stall_hold = issue_valid && !exp_ready;
    if (!rst_n) begin
      for (int r = 0; r < DEPTH; r++) begin
        m_reg[r] = '0;
        m_busy[r] = 0;
      end
      model_valid = 1;
    end else if (model_valid) begin
      if (write_en && WriteAdd != 0) begin
        m_reg[WriteAdd] = Reg_WriteData;
        m_busy[WriteAdd] = 0;
      end
      if (issue_valid && exp_ready && IssueAdd != 0) m_busy[IssueAdd] = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic rst, input logic we, input logic [AW-1:0] wa,
                        input logic [XLEN-1:0] wd, input logic [AW-1:0] ra0,
                        input logic [AW-1:0] ra1, input logic iv, input logic [AW-1:0] ia);
    rst_n = rst;
    write_en = we;
    WriteAdd = wa;
    Reg_WriteData = wd;
    ReadAdd = {ra1, ra0};
    issue_valid = iv;
    IssueAdd = ia;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic random_cycle(input logic rst);
    logic [AW-1:0] ia;
    logic          iv;
    if (stall_hold && rst) begin
      iv = 1'b1;
      ia = IssueAdd;
    end else begin
      iv = ($urandom_range(0, 2) == 0);
      ia = AW'($urandom_range(0, 7));
    end
    set_in(rst, ($urandom_range(0, 2) == 0), AW'($urandom_range(0, 7)), $urandom,
           AW'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7)),
           iv, ia);
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // 1. Reset after arbitrary traffic.
    set_in(1'b0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    for (int n = 0; n < 6; n++) random_cycle(1'b1);
    set_in(1'b0, 1, 5, 32'h1111_2222, 5, 6, 1, 6);
    tick();
    tick();
    for (int r = 0; r < DEPTH; r += 2) begin
      set_in(1'b1, 0, 0, 0, AW'(r), AW'(r + 1), 0, 0);
      #1;
      check("reset_read0", {32'd0, Data[31:0]}, 64'd0);
      check("reset_read1", {32'd0, Data[63:32]}, 64'd0);
    end
    check("reset_busy_vec", {32'd0, busy_vec}, 64'd0);
    tick();

    // 2. Write then read.
    set_in(1'b1, 1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0);
    tick();
    set_in(1'b1, 0, 0, 0, 5, 6, 0, 0);
    #1;
    exp_q.push_back(32'hDEAD_BEEF);
    pin_data0("wr_rd_r5");
    check("wr_rd_r6", {32'd0, Data[63:32]}, 64'd0);
    tick();

    // 3. Zero register.
    set_in(1'b1, 1, 0, 32'h1234_5678, 0, 0, 1, 0);
    #1;
    check("zero_issue_ready", {63'd0, issue_ready}, 64'd1);
    tick();
    set_in(1'b1, 0, 0, 0, 0, 0, 0, 0);
    #1;
    exp_q.push_back(32'h0);
    pin_data0("zero_read");
    check("zero_busy", {63'd0, busy_vec[0]}, 64'd0);
    tick();

    // 4. Scoreboard issue / stall / writeback release.
    set_in(1'b1, 0, 0, 0, 7, 0, 1, 7);
    #1;
    check("sb_first_ready", {63'd0, issue_ready}, 64'd1);
    tick();
    set_in(1'b1, 0, 0, 0, 7, 0, 1, 7);
    #1;
    check("sb_rd_busy_r7", {63'd0, rd_busy[0]}, 64'd1);
    check("sb_second_ready", {63'd0, issue_ready}, 64'd0);
    tick();
    set_in(1'b1, 1, 7, 32'hA5A5_A5A5, 7, 0, 0, 7);
    #1;
    check("sb_wb_ready", {63'd0, issue_ready}, 64'd1);
    tick();
    set_in(1'b1, 0, 0, 0, 7, 0, 0, 0);
    #1;
    check("sb_wb_cleared", {63'd0, busy_vec[7]}, 64'd0);
    exp_q.push_back(32'hA5A5_A5A5);
    pin_data0("sb_wb_data");
    tick();

    // 5. Same-cycle clear and issue on r9 (r9 reserved first).
    set_in(1'b1, 0, 0, 0, 0, 0, 1, 9);
    tick();
    set_in(1'b1, 1, 9, 32'h0909_0909, 0, 0, 1, 9);
    tick();
    set_in(1'b1, 0, 0, 0, 9, 0, 0, 0);
    #1;
    check("clr_issue_busy9", {63'd0, busy_vec[9]}, 64'd1);
    exp_q.push_back(32'h0909_0909);
    pin_data0("clr_issue_data9");
    tick();

    // 6. Write-through visibility on r3.
    set_in(1'b1, 1, 3, 32'h1111_1111, 0, 0, 0, 0);
    tick();
    set_in(1'b1, 1, 3, 32'hCAFE_F00D, 3, 0, 0, 0);
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(32'hCAFE_F00D);
`else
    exp_q.push_back(32'h1111_1111);
`endif
    pin_data0("bypass_same_cycle");
    tick();
    set_in(1'b1, 0, 0, 0, 3, 0, 0, 0);
    #1;
    exp_q.push_back(32'hCAFE_F00D);
    pin_data0("bypass_after_edge");
    tick();

    // Randomised traffic with occasional mid-stream reset.
    for (int n = 0; n < 3000; n++) begin
      random_cycle(($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1);
    end

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
